// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, start/done handshake, stall hold and LUT-based branch redirect.
// Optional RUN-cycle counter enabled by defining PC_SEQUENCER_CYCLE_CNT_EN.
module pc_sequencer #(
    parameter int PCW        = 10,
    parameter int START_ADDR = 0,
    parameter int CNTW       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            branch,
    input  logic [1:0]      how_high,
    input  logic            halt,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_idx,
    input  logic [PCW-1:0]  cfg_target,
    output logic [PCW-1:0]  pc,
    output logic            fetch_en,
    output logic            running,
    output logic            done,
    output logic [CNTW-1:0] cycles
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [PCW-1:0]      r_pc;
    logic [3:0][PCW-1:0] r_lut;
    logic                w_run;
    logic                w_go;

    assign w_run = (r_state == S_RUN);
    // start only matters outside RUN; it (re)launches from IDLE or DONE
    assign w_go  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_lut   <= '0;
        end else begin
            // LUT write lands at the edge, so a same-cycle branch still sees the old entry
            if (cfg_we)
                r_lut[cfg_idx] <= cfg_target;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_pc    <= PCW'(START_ADDR);
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (halt)
                            r_state <= S_DONE;
                        else if (branch)
                            r_pc <= r_lut[how_high];
                        else
                            r_pc <= r_pc + PCW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PC_SEQUENCER_CYCLE_CNT_EN
    logic [CNTW-1:0] r_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cycles <= '0;
        else if (w_go)
            r_cycles <= '0;
        else if (w_run && !stall && (r_cycles != {CNTW{1'b1}}))
            r_cycles <= r_cycles + CNTW'(1);
    end

    assign cycles = r_cycles;
`else
    assign cycles = '0;
`endif

    assign pc       = r_pc;
    assign running  = w_run;
    assign done     = (r_state == S_DONE);
    assign fetch_en = w_run && !stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: model predicts each cycle, queue holds expectations.
module tb_pc_sequencer;

    localparam int PCW  = 10;
    localparam int CNTW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            start, stall, branch, halt, cfg_we;
    logic [1:0]      how_high, cfg_idx;
    logic [PCW-1:0]  cfg_target;
    logic [PCW-1:0]  pc;
    logic            fetch_en, running, done;
    logic [CNTW-1:0] cycles;

    pc_sequencer #(.PCW(PCW), .START_ADDR(0), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .branch(branch),
        .how_high(how_high), .halt(halt), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_target(cfg_target), .pc(pc), .fetch_en(fetch_en), .running(running),
        .done(done), .cycles(cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PCW-1:0]  pc;
        logic            run;
        logic            dn;
        logic [CNTW-1:0] cy;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int             m_state;   // 0 idle, 1 run, 2 done
    logic [PCW-1:0] m_pc;
    logic [PCW-1:0] m_lut [4];
    logic [CNTW-1:0] m_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_state = 0;
        m_pc    = '0;
        m_cyc   = '0;
        for (int i = 0; i < 4; i++) m_lut[i] = '0;
    endtask

    function automatic logic [CNTW-1:0] exp_cy();
`ifdef PC_SEQUENCER_CYCLE_CNT_EN
        return m_cyc;
`else
        return '0;
`endif
    endfunction

    // one clock: drive, check fetch_en, push prediction, clock, pop & compare
    task automatic cyc(input logic st, input logic sl, input logic br, input logic [1:0] hh,
                       input logic hl, input logic we, input logic [1:0] idx,
                       input logic [PCW-1:0] tgt);
        exp_t e, g;
        start = st; stall = sl; branch = br; how_high = hh; halt = hl;
        cfg_we = we; cfg_idx = idx; cfg_target = tgt;
        #1;
        chk("fetch_en", {31'd0, fetch_en}, {31'd0, (m_state == 1) && !sl});
        if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_pc = '0; m_cyc = '0;
            end
        end else if (!sl) begin
            if (m_cyc != {CNTW{1'b1}}) m_cyc = m_cyc + 1'b1;
            if (hl)      m_state = 2;
            else if (br) m_pc = m_lut[hh];
            else         m_pc = m_pc + 1'b1;
        end
        if (we) m_lut[idx] = tgt;
        e.pc = m_pc; e.run = (m_state == 1); e.dn = (m_state == 2); e.cy = exp_cy();
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk("pc",      {22'd0, pc},       {22'd0, g.pc});
        chk("running", {31'd0, running},  {31'd0, g.run});
        chk("done",    {31'd0, done},     {31'd0, g.dn});
        chk("cycles",  {16'd0, cycles},   {16'd0, g.cy});
    endtask

    task automatic free();
        cyc(0, 0, 0, 2'd0, 0, 0, 2'd0, '0);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [PCW-1:0] tgt);
        cyc(0, 0, 0, 2'd0, 0, 1, idx, tgt);
    endtask

    initial begin
        reset = 1'b1;
        start = 0; stall = 0; branch = 0; halt = 0; cfg_we = 0;
        how_high = '0; cfg_idx = '0; cfg_target = '0;
        m_reset();
        #12;
        chk("rst_pc",      {22'd0, pc},      32'd0);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_done",    {31'd0, done},    32'd0);
        chk("rst_fetch",   {31'd0, fetch_en}, 32'd0);
        chk("rst_cycles",  {16'd0, cycles},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // idle holds, then start and free-run 0..5
        free();
        cyc(1, 0, 0, 2'd0, 0, 0, 2'd0, '0);
        for (int i = 0; i < 5; i++) free();
        // LUT setup while running (pc 6, 7), then branch via idx2
        wr(2'd2, 10'h1A0);
        wr(2'd1, 10'h050);
        cyc(0, 0, 1, 2'd2, 0, 0, 2'd0, '0);
        chk("branch_1A0", {22'd0, pc}, 32'h1A0);
        free();
        // same-cycle write and branch on idx1: old entry used, new one next time
        cyc(0, 0, 1, 2'd1, 0, 1, 2'd1, 10'h060);
        chk("wr_rd_old", {22'd0, pc}, 32'h050);
        cyc(0, 0, 1, 2'd1, 0, 0, 2'd0, '0);
        chk("wr_rd_new", {22'd0, pc}, 32'h060);
        // start is ignored in RUN
        cyc(1, 0, 0, 2'd0, 0, 0, 2'd0, '0);
        // get to pc=3 and stall with branch+halt asserted
        wr(2'd0, 10'd3);
        cyc(0, 0, 1, 2'd0, 0, 0, 2'd0, '0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 2'd2, 1, 0, 2'd0, '0);
        chk("stall_hold", {22'd0, pc}, 32'd3);
        free();
        for (int i = 0; i < 5; i++) free();
        // halt beats branch at pc=9
        cyc(0, 0, 1, 2'd2, 1, 0, 2'd0, '0);
        chk("halt_pc", {22'd0, pc}, 32'd9);
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 2'd2, 0, 0, 2'd0, '0);
        cyc(1, 0, 0, 2'd0, 0, 0, 2'd0, '0);
        // wrap through 0x3FF
        wr(2'd3, 10'h3FF);
        cyc(0, 0, 1, 2'd3, 0, 0, 2'd0, '0);
        free();
        chk("wrap_pc", {22'd0, pc}, 32'd0);
        // counter: restart, 6 free, 2 stalled, halt
        cyc(0, 0, 0, 2'd0, 1, 0, 2'd0, '0);
        cyc(1, 0, 0, 2'd0, 0, 0, 2'd0, '0);
        for (int i = 0; i < 6; i++) free();
        for (int i = 0; i < 2; i++) cyc(0, 1, 0, 2'd0, 0, 0, 2'd0, '0);
        cyc(0, 0, 0, 2'd0, 1, 0, 2'd0, '0);
`ifdef PC_SEQUENCER_CYCLE_CNT_EN
        chk("cycles_7", {16'd0, cycles}, 32'd7);
`else
        chk("cycles_0", {16'd0, cycles}, 32'd0);
`endif
        free();
        // async reset mid-RUN
        cyc(1, 0, 0, 2'd0, 0, 0, 2'd0, '0);
        free(); free();
        #2 reset = 1'b1;
        #1;
        chk("async_pc",      {22'd0, pc},      32'd0);
        chk("async_running", {31'd0, running}, 32'd0);
        chk("async_done",    {31'd0, done},    32'd0);
        #1 reset = 1'b0;
        m_reset();
        @(posedge clk); #1;
        cyc(1, 0, 0, 2'd0, 0, 0, 2'd0, '0);
        free(); free();
        cyc(0, 0, 1, 2'd2, 0, 0, 2'd0, '0);
        chk("lut_cleared", {22'd0, pc}, 32'd0);
        free();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
